// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the read, writeback, issue and flush signals of the register file
// with its scoreboard.
//   master : the pipeline side. It drives the read addresses, the writeback,
//            the issue and the flush, and it receives the read data, the busy
//            flags and the pending count.
//   slave  : the register file side.
// XLEN and NREG must match the parameters of the reg_file_sb that is
// connected to this interface.
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic [AW:0]     pend_cnt;

    modport master (
        output rs1, rs2, we, rd, wd, iss_valid, iss_rd, flush,
        input  rd1, rd2, rs1_busy, rs2_busy, pend_cnt
    );

    modport slave (
        input  rs1, rs2, we, rd, wd, iss_valid, iss_rd, flush,
        output rd1, rd2, rs1_busy, rs2_busy, pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// General-purpose register file with two read ports and one writeback port.
// Optionally, writeback data is forwarded to the read ports in the same cycle.
// A per-register pending-write scoreboard supports hazard detection.
// Register x0 always reads as zero. It is never written and never pending.
// Ports:
//   clk : clock. All state updates happen on the rising edge.
//   rst : asynchronous active-high reset.
//   bus : reg_file_sb_if.slave, which carries these signals:
//         - rs1/rs2 with rd1/rd2: combinational reads.
//         - rs1_busy/rs2_busy: outstanding pending write on a source register.
//         - we/rd/wd: writeback. A writeback clears the pending mark.
//         - iss_valid/iss_rd: issue. An issue sets the pending mark.
//         - flush: clears all pending marks.
//         - pend_cnt: registered count of the pending registers.
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int AW     = $clog2(NREG);
    localparam bit BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pending_nxt_s;
    logic [AW:0]     pend_cnt_r;
    logic [AW:0]     pend_cnt_nxt_s;

    logic            wr_hit_s;
    logic            set_hit_s;
    logic            inc_s;
    logic            dec_s;
    logic            fwd1_s;
    logic            fwd2_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            busy1_s;
    logic            busy2_s;

    // Decode the writeback and issue events that actually touch state.
    always_comb begin
        wr_hit_s  = bus.we && (bus.rd != '0);
        set_hit_s = bus.iss_valid && (bus.iss_rd != '0) && !bus.flush;
    end

    // Read ports. These are zero latency, with optional writeback forwarding.
    always_comb begin
        fwd1_s  = BYP_EN && bus.we && (bus.rd == bus.rs1);
        fwd2_s  = BYP_EN && bus.we && (bus.rd == bus.rs2);
        rd1_s   = '0;
        rd2_s   = '0;
        busy1_s = 1'b0;
        busy2_s = 1'b0;
        if (bus.rs1 == '0) begin
            rd1_s   = '0;
            busy1_s = 1'b0;
        end else begin
            rd1_s   = fwd1_s ? bus.wd : regs_r[bus.rs1];
            // A forwarded writeback satisfies the hazard in the same cycle.
            busy1_s = pending_r[bus.rs1] && !fwd1_s;
        end
        if (bus.rs2 == '0) begin
            rd2_s   = '0;
            busy2_s = 1'b0;
        end else begin
            rd2_s   = fwd2_s ? bus.wd : regs_r[bus.rs2];
            busy2_s = pending_r[bus.rs2] && !fwd2_s;
        end
    end

    // Next pending vector. The clear is applied before the set so that a new
    // issue to the same register wins. A flush overrides both.
    always_comb begin
        pending_nxt_s = pending_r;
        if (wr_hit_s) begin
            pending_nxt_s[bus.rd] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (set_hit_s) begin
            pending_nxt_s[bus.iss_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (bus.flush) begin
            pending_nxt_s = '0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Next pending count. It tracks the population of pending_nxt_s
    // incrementally. A clear that is overridden by a same-register set does
    // not count.
    always_comb begin
        inc_s = set_hit_s && !pending_r[bus.iss_rd];
        dec_s = wr_hit_s && pending_r[bus.rd] &&
                !(set_hit_s && (bus.iss_rd == bus.rd));
        pend_cnt_nxt_s = pend_cnt_r;
        if (bus.flush) begin
            pend_cnt_nxt_s = '0;
        end else begin
            case ({inc_s, dec_s})
                2'b10:   pend_cnt_nxt_s = pend_cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   pend_cnt_nxt_s = pend_cnt_r - {{AW{1'b0}}, 1'b1};
                default: pend_cnt_nxt_s = pend_cnt_r;
            endcase
        end
    end

    // Register storage. Writes to x0 are dropped, so that entry stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_hit_s) begin
            regs_r[bus.rd] <= bus.wd;
        end
    end

    // Scoreboard state: the pending vector and its count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r  <= '0;
            pend_cnt_r <= '0;
        end else begin
            pending_r  <= pending_nxt_s;
            pend_cnt_r <= pend_cnt_nxt_s;
        end
    end

    assign bus.rd1      = rd1_s;
    assign bus.rd2      = rd2_s;
    assign bus.rs1_busy = busy1_s;
    assign bus.rs2_busy = busy2_s;
    assign bus.pend_cnt = pend_cnt_r;
endmodule
